syn_pcm_frame_buf: RTL and testbench
====================================

// Module: syn_pcm_frame_buf
// PURPOSE
//  Parametrised, multi-channel, ping-pong PCM frame buffer between acortex (writer) and fgyrus (reader).
//  Collects 2**ADDR_W sample frames into two banks, each frame carrying NUM_CH channels.
//  Signals pcm_rdy when a bank is full and serves random-access reads by (channel, address).
//  Adds what a fixed single-buffer link lacks: double buffering, explicit release, overflow accounting.
// PARAMETERS
//  NUM_CH    2   number of PCM channels per frame (>=1)
//  DATA_W   32   bits per channel sample
//  ADDR_W    7   log2 of frame depth; DEPTH = 2**ADDR_W samples per bank
//  CH_W      1   channel index width = max(1, $clog2(NUM_CH))
//  OVF_W    16   overflow counter width
// PORTS
//  clk          in   1               single clock; all logic on posedge
//  rst          in   1               asynchronous, active-high reset
//  in_vld       in   1               one multi-channel sample present on in_data this cycle
//  in_data      in   NUM_CH*DATA_W   ch0 in [DATA_W-1:0], chN in [(N+1)*DATA_W-1 -: DATA_W]
//  pcm_rdy      out  1               read bank holds a complete frame
//  pcm_rd_en    in   1               read strobe
//  pcm_rd_ch    in   CH_W            channel to read
//  pcm_rd_addr  in   ADDR_W          sample index within frame; 0 is the oldest sample
//  pcm_rd_vld   out  1               pcm_rd_data valid (1 cycle after accepted pcm_rd_en)
//  pcm_rd_data  out  DATA_W          read data
//  pcm_done     in   1               single-cycle pulse from fgyrus: release current read bank
//  ovf_flag     out  1               sticky: at least one sample dropped
//  ovf_cnt      out  OVF_W           dropped-sample count, saturating at all-ones
//  ovf_clr      in   1               synchronous clear of ovf_flag and ovf_cnt
// BEHAVIOUR
//  Reset (async, any time, incl. mid-frame): all of the following go to 0; partial frame data is discarded.
//   - State: full[1:0], wbank, rbank, wr_ptr.
//   - Outputs: pcm_rdy, pcm_rd_vld, pcm_rd_data, ovf_flag, ovf_cnt.
//  Write side:
//   - Sample accepted when in_vld && !full[wbank].
//   - Accepted sample is stored at bank[wbank][wr_ptr], all channels; wr_ptr increments (ADDR_W wrap).
//   - Accept at wr_ptr==DEPTH-1: full[wbank]<=1 and wr_ptr<=0.
//  Bank steering, evaluated every cycle after the update:
//   - If full[wbank] && !full[~wbank], wbank toggles next cycle.
//   - If both banks are full, the writer is blocked.
//  Drop:
//   - Condition: in_vld && full[wbank]. The sample is not stored.
//   - ovf_flag<=1; ovf_cnt+1, saturating.
//   - ovf_clr has priority over a same-cycle drop: the result is 0/0.
//  Read side:
//   - pcm_rdy = full[rbank], registered from the state.
//   - Rise latency: 1 cycle after the accept of the last frame sample.
//   - Read accepted when pcm_rd_en && pcm_rdy.
//   - Cycle after an accepted read: pcm_rd_vld=1 and pcm_rd_data=bank[rbank][ch][addr].
//   - If pcm_rd_ch>=NUM_CH, pcm_rd_data=0 (pcm_rd_vld still 1).
//   - pcm_rd_en while !pcm_rdy is ignored: pcm_rd_vld=0 and pcm_rd_data holds.
//  Release:
//   - Applies when pcm_done && pcm_rdy: full[rbank]<=0, rbank toggles; pcm_rdy drops next cycle.
//   - If the other bank was already full, pcm_rdy re-asserts the cycle after that.
//   - pcm_done while !pcm_rdy is ignored.
//   - pcm_rd_en in the same cycle as pcm_done still reads the releasing bank.
//  Simultaneous events:
//   - Fill-complete and release in the same cycle both apply.
//   - Steering then sees the freed bank, so no sample is dropped in the following cycle.
//  Ordering: rbank always points at the older full bank; frames are delivered in fill order, never reordered.
//  Storage: 2*NUM_CH*DEPTH*DATA_W bits, inferable as 1R1W RAM with a registered read.
// TESTING (NUM_CH=2, DATA_W=16, ADDR_W=3, DEPTH=8)
//  1 Fill one frame:
//    - Stimulus: 8 in_vld with ch0=k, ch1=0x100+k for k=0..7.
//    - Response: pcm_rdy rises 1 cycle after the 8th sample.
//    - Response: rd(ch1, addr5) -> pcm_rd_vld next cycle, data 0x105.
//  2 Ping-pong:
//    - Stimulus: 16 samples (k=0..15), then pcm_done.
//    - Response: pcm_rdy drops 1 cycle, then re-asserts.
//    - Response: rd(ch0, addr0) returns 8. No drops.
//  3 Overflow:
//    - Stimulus: 19 samples with no pcm_done.
//    - Response: samples 17-19 dropped; ovf_flag=1, ovf_cnt=3.
//    - Response: after pcm_done, the next sample lands at bank0 addr0.
//    - Response: ovf_clr -> ovf_flag=0, ovf_cnt=0.
//  4 Simultaneous events:
//    - Stimulus: pcm_done in the same cycle as the 16th accepted sample, then a 17th sample the next cycle.
//    - Response: sample 17 is accepted, ovf_cnt=0, pcm_rdy stays 1 after a 1-cycle dip.
//  5 Illegal accesses:
//    - Stimulus: pcm_rd_en and pcm_done while pcm_rdy=0.
//    - Response: no pcm_rd_vld, state unchanged.
//    - Stimulus: rd(ch=1) with NUM_CH=1 build.
//    - Response: data 0.
//  6 Reset mid-frame:
//    - Stimulus: assert rst after 5 samples, then 8 samples k=0x20..0x27.
//    - Response: pcm_rdy rises after the 8th sample only; rd(ch0, addr0)=0x20.

Source files
------------

// File: rtl/syn_pcm_frame_buf.sv
// -----------------------------------------------------------------------------
// syn_pcm_frame_buf
//
// Ping-pong, multi-channel PCM frame buffer. The writer (acortex) streams one
// multi-channel sample per in_vld into the current write bank. Once 2**ADDR_W
// samples have been collected the bank is marked full and handed to the reader
// (fgyrus). The reader does random-access reads by (channel, sample index)
// and releases the bank with pcm_done. Samples that arrive while both banks are
// full are dropped and counted.
//
// Ports
//   clk          in   single clock, all logic on its rising edge
//   rst          in   asynchronous, active-high reset
//   in_vld       in   one multi-channel sample is present on in_data
//   in_data      in   NUM_CH*DATA_W, channel n in [(n+1)*DATA_W-1 -: DATA_W]
//   pcm_rdy      out  read bank holds a complete frame
//   pcm_rd_en    in   read strobe, honoured only while pcm_rdy
//   pcm_rd_ch    in   channel to read
//   pcm_rd_addr  in   sample index within the frame, 0 is the oldest sample
//   pcm_rd_vld   out  pcm_rd_data valid, one cycle after an accepted read
//   pcm_rd_data  out  read data, holds its value between accepted reads
//   pcm_done     in   release the current read bank (honoured only while pcm_rdy)
//   ovf_flag     out  sticky: at least one sample was dropped
//   ovf_cnt      out  dropped-sample count, saturating at all-ones
//   ovf_clr      in   synchronous clear of ovf_flag/ovf_cnt, wins over a drop
// -----------------------------------------------------------------------------
module syn_pcm_frame_buf #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int CH_W   = 1,
    parameter int OVF_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     pcm_rdy,
    input  logic                     pcm_rd_en,
    input  logic [CH_W-1:0]          pcm_rd_ch,
    input  logic [ADDR_W-1:0]        pcm_rd_addr,
    output logic                     pcm_rd_vld,
    output logic [DATA_W-1:0]        pcm_rd_data,
    input  logic                     pcm_done,
    output logic                     ovf_flag,
    output logic [OVF_W-1:0]         ovf_cnt,
    input  logic                     ovf_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WORDS = 2 * DEPTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_W-1:0]  OVF_MAX   = {OVF_W{1'b1}};
    localparam logic [OVF_W-1:0]  OVF_ONE   = {{(OVF_W-1){1'b0}}, 1'b1};

    // Picks one channel out of a stored multi-channel word; channels that do
    // not exist in this build read as zero.
    function automatic logic [DATA_W-1:0] ch_select(
        input logic [NUM_CH*DATA_W-1:0] word,
        input logic [CH_W-1:0]          ch
    );
        logic [DATA_W-1:0] sel;
        sel = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) begin
                sel = word[i*DATA_W +: DATA_W];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Both banks live in one array: word address = {bank, sample index}.
    logic [NUM_CH*DATA_W-1:0] mem_r [WORDS];

    logic [1:0]        full_r;
    logic              wbank_r;
    logic              rbank_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic              pcm_rdy_r;
    logic              pcm_rd_vld_r;
    logic [DATA_W-1:0] pcm_rd_data_r;
    logic              ovf_flag_r;
    logic [OVF_W-1:0]  ovf_cnt_r;

    logic              wr_acc_s;
    logic              drop_s;
    logic              fill_done_s;
    logic              rel_s;
    logic              rd_acc_s;
    logic [1:0]        full_nxt_s;
    logic              wbank_nxt_s;
    logic              rbank_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic              rdy_nxt_s;
    logic              ovf_flag_nxt_s;
    logic [OVF_W-1:0]  ovf_cnt_nxt_s;
    logic [NUM_CH*DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] rd_sel_s;

    // Accept/drop/release/read qualification from the current state.
    always_comb begin
        wr_acc_s    = in_vld && !full_r[wbank_r];
        drop_s      = in_vld && full_r[wbank_r];
        fill_done_s = wr_acc_s && (wr_ptr_r == LAST_ADDR);
        rel_s       = pcm_done && pcm_rdy_r;
        rd_acc_s    = pcm_rd_en && pcm_rdy_r;
    end

    // Next bank state. Fill-complete and release never target the same bank:
    // the writer is blocked on a full bank and the reader only releases a full
    // one, so both updates can be applied together.
    always_comb begin
        full_nxt_s = full_r;
        if (fill_done_s) begin
            full_nxt_s[wbank_r] = 1'b1;
        end else begin
            full_nxt_s[wbank_r] = full_r[wbank_r];
        end
        if (rel_s) begin
            full_nxt_s[rbank_r] = 1'b0;
            rbank_nxt_s         = ~rbank_r;
        end else begin
            rbank_nxt_s         = rbank_r;
        end

        // Steering looks at the post-update flags so the writer moves to the
        // free bank on the same edge that closes (or frees) a bank; a sample
        // arriving on the very next cycle is therefore never dropped.
        if (full_nxt_s[wbank_r] && !full_nxt_s[~wbank_r]) begin
            wbank_nxt_s = ~wbank_r;
        end else begin
            wbank_nxt_s = wbank_r;
        end

        // The pointer wraps to zero naturally after the last index.
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + ADDR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // A release always shows one cycle of !pcm_rdy, even when the other
        // bank is already waiting, so the reader sees a clean frame boundary.
        if (rel_s) begin
            rdy_nxt_s = 1'b0;
        end else begin
            rdy_nxt_s = full_nxt_s[rbank_nxt_s];
        end
    end

    // Overflow accounting; a clear in the same cycle as a drop wins.
    always_comb begin
        ovf_flag_nxt_s = ovf_flag_r;
        ovf_cnt_nxt_s  = ovf_cnt_r;
        if (ovf_clr) begin
            ovf_flag_nxt_s = 1'b0;
            ovf_cnt_nxt_s  = {OVF_W{1'b0}};
        end else if (drop_s) begin
            ovf_flag_nxt_s = 1'b1;
            if (ovf_cnt_r != OVF_MAX) begin
                ovf_cnt_nxt_s = ovf_cnt_r + OVF_ONE;
            end else begin
                ovf_cnt_nxt_s = ovf_cnt_r;
            end
        end else begin
            ovf_flag_nxt_s = ovf_flag_r;
            ovf_cnt_nxt_s  = ovf_cnt_r;
        end
    end

    // Read-port address and channel selection for the registered read.
    always_comb begin
        rd_word_s = mem_r[{rbank_r, pcm_rd_addr}];
        rd_sel_s  = ch_select(rd_word_s, pcm_rd_ch);
    end

    // Sample storage write port; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[{wbank_r, wr_ptr_r}] <= in_data;
        end
    end

    // Control state, overflow accounting and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r        <= 2'b00;
            wbank_r       <= 1'b0;
            rbank_r       <= 1'b0;
            wr_ptr_r      <= {ADDR_W{1'b0}};
            pcm_rdy_r     <= 1'b0;
            pcm_rd_vld_r  <= 1'b0;
            pcm_rd_data_r <= {DATA_W{1'b0}};
            ovf_flag_r    <= 1'b0;
            ovf_cnt_r     <= {OVF_W{1'b0}};
        end else begin
            full_r       <= full_nxt_s;
            wbank_r      <= wbank_nxt_s;
            rbank_r      <= rbank_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            pcm_rdy_r    <= rdy_nxt_s;
            pcm_rd_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                pcm_rd_data_r <= rd_sel_s;
            end
            ovf_flag_r   <= ovf_flag_nxt_s;
            ovf_cnt_r    <= ovf_cnt_nxt_s;
        end
    end

    assign pcm_rdy     = pcm_rdy_r;
    assign pcm_rd_vld  = pcm_rd_vld_r;
    assign pcm_rd_data = pcm_rd_data_r;
    assign ovf_flag    = ovf_flag_r;
    assign ovf_cnt     = ovf_cnt_r;

endmodule

// File: tb/tb_syn_pcm_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_syn_pcm_frame_buf
//
// Bench for syn_pcm_frame_buf (NUM_CH=2, DATA_W=16, ADDR_W=3) plus a small
// NUM_CH=1 instance. A frame-queue model predicts every output each cycle;
// directed scenarios add literal expectations, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_syn_pcm_frame_buf;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CH_W   = 1;
    localparam int OVF_W  = 16;
    localparam int DEPTH  = 8;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic [31:0] in_data;
    logic        pcm_rdy;
    logic        pcm_rd_en;
    logic [0:0]  pcm_rd_ch;
    logic [2:0]  pcm_rd_addr;
    logic        pcm_rd_vld;
    logic [15:0] pcm_rd_data;
    logic        pcm_done;
    logic        ovf_flag;
    logic [15:0] ovf_cnt;
    logic        ovf_clr;

    // single-channel instance signals
    logic        s_in_vld;
    logic [15:0] s_in_data;
    logic        s_rdy;
    logic        s_rd_en;
    logic [0:0]  s_rd_ch;
    logic [2:0]  s_rd_addr;
    logic        s_rd_vld;
    logic [15:0] s_rd_data;
    logic        s_done;
    logic        s_flag;
    logic [15:0] s_cnt;
    logic        s_clr;

    syn_pcm_frame_buf #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                        .CH_W(CH_W), .OVF_W(OVF_W)) u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
        .pcm_rdy(pcm_rdy), .pcm_rd_en(pcm_rd_en), .pcm_rd_ch(pcm_rd_ch),
        .pcm_rd_addr(pcm_rd_addr), .pcm_rd_vld(pcm_rd_vld),
        .pcm_rd_data(pcm_rd_data), .pcm_done(pcm_done), .ovf_flag(ovf_flag),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    syn_pcm_frame_buf #(.NUM_CH(1), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                        .CH_W(1), .OVF_W(OVF_W)) u_dut1 (
        .clk(clk), .rst(rst), .in_vld(s_in_vld), .in_data(s_in_data),
        .pcm_rdy(s_rdy), .pcm_rd_en(s_rd_en), .pcm_rd_ch(s_rd_ch),
        .pcm_rd_addr(s_rd_addr), .pcm_rd_vld(s_rd_vld),
        .pcm_rd_data(s_rd_data), .pcm_done(s_done), .ovf_flag(s_flag),
        .ovf_cnt(s_cnt), .ovf_clr(s_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: queue of completed frames ----------------
    logic [15:0] fdata [64][DEPTH][NUM_CH];
    int          full_q[$];
    int          cur_id;
    int          part_cnt;
    logic        exp_rdy;
    logic        exp_vld;
    logic [15:0] exp_data;
    logic        exp_flag;
    logic [15:0] exp_cnt;

    int n_checks;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        full_q.delete();
        part_cnt = 0;
        exp_rdy  = 1'b0;
        exp_vld  = 1'b0;
        exp_data = 16'h0;
        exp_flag = 1'b0;
        exp_cnt  = 16'h0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit acc, drop, rel, rd;
        if (rst) return;
        acc  = in_vld && (full_q.size() < 2);
        drop = in_vld && (full_q.size() == 2);
        rel  = pcm_done && exp_rdy;
        rd   = pcm_rd_en && exp_rdy;
        exp_vld = rd;
        if (rd) begin
            if (int'(pcm_rd_ch) < NUM_CH) exp_data = fdata[full_q[0]][pcm_rd_addr][pcm_rd_ch];
            else exp_data = 16'h0;
        end
        if (acc) begin
            fdata[cur_id][part_cnt][0] = in_data[15:0];
            fdata[cur_id][part_cnt][1] = in_data[31:16];
            part_cnt++;
            if (part_cnt == DEPTH) begin
                full_q.push_back(cur_id);
                cur_id   = (cur_id + 1) % 64;
                part_cnt = 0;
            end
        end
        if (rel) void'(full_q.pop_front());
        exp_rdy = !rel && (full_q.size() > 0);
        if (ovf_clr) begin
            exp_flag = 1'b0;
            exp_cnt  = 16'h0;
        end else if (drop) begin
            exp_flag = 1'b1;
            if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'h1;
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("pcm_rdy",     {31'h0, pcm_rdy},    {31'h0, exp_rdy});
        chk("pcm_rd_vld",  {31'h0, pcm_rd_vld}, {31'h0, exp_vld});
        chk("pcm_rd_data", {16'h0, pcm_rd_data}, {16'h0, exp_data});
        chk("ovf_flag",    {31'h0, ovf_flag},   {31'h0, exp_flag});
        chk("ovf_cnt",     {16'h0, ovf_cnt},    {16'h0, exp_cnt});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1);
        in_vld  = 1'b1;
        in_data = {c1, c0};
        step();
        in_vld  = 1'b0;
    endtask

    task automatic done_pulse();
        pcm_done = 1'b1;
        step();
        pcm_done = 1'b0;
    endtask

    task automatic rd(input logic [0:0] ch, input logic [2:0] a);
        pcm_rd_en   = 1'b1;
        pcm_rd_ch   = ch;
        pcm_rd_addr = a;
        step();
        pcm_rd_en   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cur_id   = 0;
        rst = 1'b1; in_vld = 1'b0; in_data = 32'h0; pcm_rd_en = 1'b0;
        pcm_rd_ch = 1'b0; pcm_rd_addr = 3'd0; pcm_done = 1'b0; ovf_clr = 1'b0;
        s_in_vld = 1'b0; s_in_data = 16'h0; s_rd_en = 1'b0; s_rd_ch = 1'b0;
        s_rd_addr = 3'd0; s_done = 1'b0; s_clr = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset pcm_rdy",    {31'h0, pcm_rdy}, 32'h0);
        chk("reset pcm_rd_vld", {31'h0, pcm_rd_vld}, 32'h0);
        chk("reset ovf_cnt",    {16'h0, ovf_cnt}, 32'h0);
        step();
        rst = 1'b0;

        // 1: fill one frame
        for (int k = 0; k < 8; k++) begin
            send(16'(k), 16'(16'h100 + k));
            if (k == 6) chk("t1 rdy before last", {31'h0, pcm_rdy}, 32'h0);
        end
        chk("t1 rdy after last", {31'h0, pcm_rdy}, 32'h1);
        rd(1'b1, 3'd5);
        chk("t1 rd vld", {31'h0, pcm_rd_vld}, 32'h1);
        chk("t1 rd data", {16'h0, pcm_rd_data}, 32'h105);

        // 2: ping-pong
        do_reset();
        for (int k = 0; k < 16; k++) send(16'(k), 16'(16'h100 + k));
        chk("t2 rdy", {31'h0, pcm_rdy}, 32'h1);
        done_pulse();
        chk("t2 rdy dip", {31'h0, pcm_rdy}, 32'h0);
        step();
        chk("t2 rdy back", {31'h0, pcm_rdy}, 32'h1);
        rd(1'b0, 3'd0);
        chk("t2 rd data", {16'h0, pcm_rd_data}, 32'h8);
        chk("t2 no drops", {16'h0, ovf_cnt}, 32'h0);

        // 3: overflow
        do_reset();
        for (int k = 0; k < 19; k++) send(16'(k), 16'(16'h100 + k));
        chk("t3 ovf_flag", {31'h0, ovf_flag}, 32'h1);
        chk("t3 ovf_cnt", {16'h0, ovf_cnt}, 32'h3);
        done_pulse();
        send(16'h77, 16'h177);
        done_pulse();
        for (int k = 1; k < 8; k++) send(16'(16'h77 + k), 16'(16'h177 + k));
        chk("t3 rdy bank0", {31'h0, pcm_rdy}, 32'h1);
        rd(1'b0, 3'd0);
        chk("t3 bank0 addr0", {16'h0, pcm_rd_data}, 32'h77);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3 clr flag", {31'h0, ovf_flag}, 32'h0);
        chk("t3 clr cnt", {16'h0, ovf_cnt}, 32'h0);

        // 4: release coincident with fill-complete
        do_reset();
        for (int k = 0; k < 15; k++) send(16'(k), 16'(16'h100 + k));
        pcm_done = 1'b1;
        send(16'd15, 16'h10f);
        pcm_done = 1'b0;
        chk("t4 rdy dip", {31'h0, pcm_rdy}, 32'h0);
        send(16'd16, 16'h110);
        chk("t4 rdy back", {31'h0, pcm_rdy}, 32'h1);
        chk("t4 no drop", {16'h0, ovf_cnt}, 32'h0);

        // 5: illegal accesses
        do_reset();
        pcm_rd_en = 1'b1;
        pcm_done  = 1'b1;
        step();
        pcm_rd_en = 1'b0;
        pcm_done  = 1'b0;
        chk("t5 no vld", {31'h0, pcm_rd_vld}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            send(16'(16'h40 + k), 16'(16'h140 + k));
            if (k == 6) chk("t5 rdy before last", {31'h0, pcm_rdy}, 32'h0);
        end
        chk("t5 rdy after last", {31'h0, pcm_rdy}, 32'h1);
        rd(1'b1, 3'd7);
        chk("t5 rd data", {16'h0, pcm_rd_data}, 32'h147);
        for (int k = 0; k < 8; k++) begin
            s_in_vld  = 1'b1;
            s_in_data = 16'(16'h50 + k);
            step();
        end
        s_in_vld = 1'b0;
        chk("t5 1ch rdy", {31'h0, s_rdy}, 32'h1);
        s_rd_en = 1'b1; s_rd_ch = 1'b1; s_rd_addr = 3'd2;
        step();
        chk("t5 1ch bad ch vld", {31'h0, s_rd_vld}, 32'h1);
        chk("t5 1ch bad ch data", {16'h0, s_rd_data}, 32'h0);
        s_rd_ch = 1'b0;
        step();
        s_rd_en = 1'b0;
        chk("t5 1ch ch0 data", {16'h0, s_rd_data}, 32'h52);

        // 6: reset mid-frame
        do_reset();
        for (int k = 0; k < 5; k++) send(16'(16'h10 + k), 16'h0);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send(16'(16'h20 + k), 16'(16'h120 + k));
            if (k == 6) chk("t6 rdy before last", {31'h0, pcm_rdy}, 32'h0);
        end
        chk("t6 rdy after last", {31'h0, pcm_rdy}, 32'h1);
        rd(1'b0, 3'd0);
        chk("t6 rd data", {16'h0, pcm_rd_data}, 32'h20);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            in_vld      = ($urandom_range(0, 99) < 70);
            in_data     = $urandom;
            pcm_rd_en   = 1'($urandom_range(0, 1));
            pcm_rd_ch   = 1'($urandom_range(0, 1));
            pcm_rd_addr = 3'($urandom_range(0, 7));
            pcm_done    = ($urandom_range(0, 99) < 8);
            ovf_clr     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 2) do_reset();
            else step();
        end
        in_vld = 1'b0; pcm_rd_en = 1'b0; pcm_done = 1'b0; ovf_clr = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
